// File: rtl/serial_digit_adder.sv
// -----------------------------------------------------------------------------
// serial_digit_adder
//   Multi-cycle adder computing a + b + cin over WIDTH bits. Each clock adds
//   DIGIT bits through one (DIGIT+1)-bit adder slice, and a registered carry
//   links the digits. The operation takes NDIG = WIDTH/DIGIT RUN cycles and
//   then one DONE cycle. Area is traded for latency.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request; accepted only in IDLE or DONE
//   a, b   in   WIDTH  operands; latched on the accepting edge
//   cin    in   1      carry-in; latched on the accepting edge
//   busy   out  1      addition in progress (RUN)
//   done   out  1      single-cycle pulse; sum/cout/ovf are valid
//   sum    out  WIDTH  result bits
//   cout   out  1      carry out of the MSB
//   ovf    out  1      signed overflow (carry into MSB ^ carry out of MSB)
// -----------------------------------------------------------------------------
module serial_digit_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
      $error("serial_digit_adder: WIDTH must be >= 1 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // One-hot decode of the digit counter, shared by the operand mux and the
  // sum write-back.
  logic [NDIG-1:0] dig_sel;
  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig_sel
      assign dig_sel[gi] = (cnt_q == CW'(gi));
    end
  endgenerate

  // Current digit of each operand.
  logic [DIGIT-1:0] a_cur, b_cur;
  always_comb begin
    a_cur = '0;
    b_cur = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (dig_sel[i]) begin
        a_cur = a_q[i*DIGIT +: DIGIT];
        b_cur = b_q[i*DIGIT +: DIGIT];
      end
    end
  end

  // The slice is one bit wider than a digit; its MSB is the next carry.
  logic [DIGIT:0] slice;
  logic           msb_carry_in;
  assign slice = {1'b0, a_cur} + {1'b0, b_cur} + {{DIGIT{1'b0}}, carry_q};
  // On the last digit, the carry into the result MSB is recovered from the
  // MSB sum bit: s = a ^ b ^ c_in, hence c_in = a ^ b ^ s.
  assign msb_carry_in = a_cur[DIGIT-1] ^ b_cur[DIGIT-1] ^ slice[DIGIT-1];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        for (int i = 0; i < NDIG; i++) begin
          if (dig_sel[i]) begin
            sum_d[i*DIGIT +: DIGIT] = slice[DIGIT-1:0];
          end
        end
        carry_d = slice[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cout_d  = slice[DIGIT];
          ovf_d   = msb_carry_in ^ slice[DIGIT];
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_digit_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_digit_adder
//   Directed self-checking bench. Three instances share the clock, the reset
//   and the operand inputs:
//     u_w4d1  WIDTH=4 DIGIT=1   exhaustive {cin,a,b}
//     u_w8d2  WIDTH=8 DIGIT=2   corner vectors, back-to-back, reset abort
//     u_w8d8  WIDTH=8 DIGIT=8   single-digit degenerate case
// -----------------------------------------------------------------------------
module tb_serial_digit_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a_in, b_in;
  logic       cin_in;
  logic       start4, start2, start8;

  logic       busy4, done4, cout4, ovf4;
  logic [3:0] sum4;
  logic       busy2, done2, cout2, ovf2;
  logic [7:0] sum2;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_digit_adder #(.WIDTH(4), .DIGIT(1)) u_w4d1 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a_in[3:0]), .b(b_in[3:0]),
    .cin(cin_in), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  serial_digit_adder #(.WIDTH(8), .DIGIT(2)) u_w8d2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a_in), .b(b_in),
    .cin(cin_in), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  serial_digit_adder #(.WIDTH(8), .DIGIT(8)) u_w8d8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a_in), .b(b_in),
    .cin(cin_in), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic done_of(input int w);
    case (w)
      0:       return done4;
      1:       return done2;
      default: return done8;
    endcase
  endfunction

  function automatic logic busy_of(input int w);
    case (w)
      0:       return busy4;
      1:       return busy2;
      default: return busy8;
    endcase
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w)
      0:       start4 = v;
      1:       start2 = v;
      default: start8 = v;
    endcase
  endtask

  // One full transaction: start for one edge, wait (bounded) for done,
  // capture the result, then confirm done drops after one cycle.
  task automatic run_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                        input logic cv, output logic [7:0] s, output logic c,
                        output logic o, output int edges, output int busy_n);
    @(negedge clk);
    a_in = av; b_in = bv; cin_in = cv;
    set_start(w, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(w, 1'b0);
    edges  = 0;
    busy_n = 0;
    while (!done_of(w) && edges < 40) begin
      if (busy_of(w)) busy_n++;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check("done_seen", 32'(done_of(w)), 32'd1);
    case (w)
      0:       begin s = {4'h0, sum4}; c = cout4; o = ovf4; end
      1:       begin s = sum2;         c = cout2; o = ovf2; end
      default: begin s = sum8;         c = cout8; o = ovf8; end
    endcase
    check("busy_at_done", 32'(busy_of(w)), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("done_pulse", 32'(done_of(w)), 32'd0);
  endtask

  initial begin
    logic [7:0] s;
    logic       c, o;
    int         edges, busy_n, dn, e0;
    logic [4:0] exp5;

    rst_n  = 1'b0;
    a_in   = '0;
    b_in   = '0;
    cin_in = 1'b0;
    start4 = 1'b0;
    start2 = 1'b0;
    start8 = 1'b0;

    // Reset state
    #1;
    check("rst_busy", 32'(busy2), 32'd0);
    check("rst_done", 32'(done2), 32'd0);
    check("rst_sum",  32'(sum2),  32'd0);
    check("rst_cout", 32'(cout2), 32'd0);
    check("rst_ovf",  32'(ovf2),  32'd0);
    check("rst_sum4", 32'(sum4),  32'd0);
    check("rst_sum8", 32'(sum8),  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive WIDTH=4 DIGIT=1
    for (int v = 0; v < 512; v++) begin
      logic [8:0] vv;
      logic [3:0] av, bv;
      logic       cv, ovf_exp;
      vv   = 9'(v);
      cv   = vv[8];
      av   = vv[7:4];
      bv   = vv[3:0];
      exp5 = {1'b0, av} + {1'b0, bv} + {4'h0, cv};
      ovf_exp = (av[3] == bv[3]) && (exp5[3] != av[3]);
      e0 = errors;
      run_op(0, {4'h0, av}, {4'h0, bv}, cv, s, c, o, edges, busy_n);
      check("exh_result", 32'({c, s[3:0]}), 32'(exp5));
      check("exh_ovf", 32'(o), 32'(ovf_exp));
      check("exh_latency", 32'(edges), 32'd4);
      if (errors == e0)
        $display("PASSED exh a=%h b=%h cin=%0d -> cout=%0d sum=%h ovf=%0d", av, bv, cv, c, s[3:0], o);
    end

    // WIDTH=8 DIGIT=2: FF + 01
    run_op(1, 8'hFF, 8'h01, 1'b0, s, c, o, edges, busy_n);
    $display("w8d2 FF+01+0 -> sum=%h cout=%0d ovf=%0d edges=%0d busy=%0d", s, c, o, edges, busy_n);
    check("ff01_sum",  32'(s), 32'h00);
    check("ff01_cout", 32'(c), 32'd1);
    check("ff01_ovf",  32'(o), 32'd0);
    check("ff01_latency", 32'(edges), 32'd4);
    check("ff01_busy_cycles", 32'(busy_n), 32'd4);

    // Signed overflow without carry-out
    run_op(1, 8'h7F, 8'h01, 1'b0, s, c, o, edges, busy_n);
    $display("w8d2 7F+01+0 -> sum=%h cout=%0d ovf=%0d", s, c, o);
    check("7f01_sum",  32'(s), 32'h80);
    check("7f01_cout", 32'(c), 32'd0);
    check("7f01_ovf",  32'(o), 32'd1);

    // Signed overflow with carry-out and carry-in
    run_op(1, 8'h80, 8'h80, 1'b1, s, c, o, edges, busy_n);
    $display("w8d2 80+80+1 -> sum=%h cout=%0d ovf=%0d", s, c, o);
    check("8080_sum",  32'(s), 32'h01);
    check("8080_cout", 32'(c), 32'd1);
    check("8080_ovf",  32'(o), 32'd1);

    // Degenerate WIDTH=8 DIGIT=8
    run_op(2, 8'hA5, 8'h5A, 1'b1, s, c, o, edges, busy_n);
    $display("w8d8 A5+5A+1 -> sum=%h cout=%0d ovf=%0d edges=%0d", s, c, o, edges);
    check("a55a_sum",  32'(s), 32'h00);
    check("a55a_cout", 32'(c), 32'd1);
    check("a55a_ovf",  32'(o), 32'd0);
    check("a55a_latency", 32'(edges), 32'd1);
    check("a55a_busy_cycles", 32'(busy_n), 32'd1);

    // Start held high: done on edges 4, 9, 14 after the first accept (edge 0)
    @(negedge clk);
    a_in = 8'h10; b_in = 8'h20; cin_in = 1'b0;
    start2 = 1'b1;
    dn = 0;
    for (int e = 0; e < 15; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (done2) begin
        dn++;
        $display("w8d2 back-to-back done #%0d at edge %0d sum=%h", dn, e, sum2);
        check("b2b_edge", 32'(e), 32'(4 + 5 * (dn - 1)));
        check("b2b_sum", 32'(sum2), 32'h30);
      end
    end
    start2 = 1'b0;
    check("b2b_count", 32'(dn), 32'd3);
    @(posedge clk);
    @(negedge clk);

    // Start pulse during RUN is ignored
    a_in = 8'h03; b_in = 8'h04; cin_in = 1'b0;
    start2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a_in = 8'h50; b_in = 8'h50; cin_in = 1'b1;
    start2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
    a_in = 8'h00; b_in = 8'h00; cin_in = 1'b0;
    dn = 0;
    s  = 8'h00;
    for (int e = 0; e < 10; e++) begin
      if (done2) begin
        dn++;
        s = sum2;
      end
      @(posedge clk);
      @(negedge clk);
    end
    $display("w8d2 ignored mid-run start -> dones=%0d sum=%h", dn, s);
    check("ignore_count", 32'(dn), 32'd1);
    check("ignore_sum", 32'(s), 32'h07);

    // Reset in the 2nd RUN cycle aborts the operation
    a_in = 8'hFF; b_in = 8'hFF; cin_in = 1'b1;
    start2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("w8d2 async reset mid-run -> busy=%0d done=%0d sum=%h cout=%0d ovf=%0d",
             busy2, done2, sum2, cout2, ovf2);
    check("abort_busy", 32'(busy2), 32'd0);
    check("abort_done", 32'(done2), 32'd0);
    check("abort_sum",  32'(sum2),  32'd0);
    check("abort_cout", 32'(cout2), 32'd0);
    check("abort_ovf",  32'(ovf2),  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int e = 0; e < 8; e++) begin
      if (done2) dn++;
      @(posedge clk);
      @(negedge clk);
    end
    check("abort_no_done", 32'(dn), 32'd0);

    run_op(1, 8'h12, 8'h34, 1'b1, s, c, o, edges, busy_n);
    $display("w8d2 12+34+1 after reset -> sum=%h cout=%0d ovf=%0d", s, c, o);
    check("post_rst_sum",  32'(s), 32'h47);
    check("post_rst_cout", 32'(c), 32'd0);
    check("post_rst_ovf",  32'(o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
